// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Writable-store microcode controller for the matrix-multiply cores. A host
//   loads microwords while idle, then pulses start; the sequencer walks the
//   store, emitting one control word per non-stalled RUN cycle, with
//   conditional branches and a small call/return stack.
//
//   Microword layout, MSB..LSB:
//     ops[OP_W] | halt | ret | call | bt | cond_sel[COND_W] | jump_addr[ADDR_W]
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   ld_en      : microcode write strobe, honoured in IDLE only
//   ld_addr    : write address (low AW bits used)
//   ld_data    : microword to write
//   start      : start pulse, honoured in IDLE only
//   start_addr : first micro-address (low AW bits used)
//   abort      : abandon the running program, back to IDLE
//   stall      : freeze micro-PC and stack, suppress ops
//   cond_in    : branch condition flags, bit 0 unused
//   ops        : control word, zero when ops_valid is low
//   ops_valid  : ops is meaningful this cycle
//   upc        : current micro-PC, zero-extended
//   busy       : sequencer not in IDLE
//   done       : one-cycle pulse after a normal halt
//   err        : sticky stack overflow/underflow flag

module microcode_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 64,
  parameter int OP_W        = 51,
  parameter int COND_W      = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ld_en,
  input  logic [ADDR_W-1:0]               ld_addr,
  input  logic [OP_W+4+COND_W+ADDR_W-1:0] ld_data,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               start_addr,
  input  logic                            abort,
  input  logic                            stall,
  input  logic [2**COND_W-1:0]            cond_in,
  output logic [OP_W-1:0]                 ops,
  output logic                            ops_valid,
  output logic [ADDR_W-1:0]               upc,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int MW  = OP_W + 4 + COND_W + ADDR_W;
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [AW-1:0]     upc_r, upc_n;
  logic [SPW-1:0]    sp, sp_n;
  logic              err_n;
  logic              push_en;

  logic [MW-1:0]     store [DEPTH];
  logic [AW-1:0]     stack [STACK_DEPTH];

  logic [MW-1:0]     word;
  logic [OP_W-1:0]   w_ops;
  logic              w_halt, w_ret, w_call, w_bt;
  logic [COND_W-1:0] w_cond;
  logic [ADDR_W-1:0] w_jump;
  logic              take;
  logic [AW-1:0]     upc_inc;
  logic [SPW-1:0]    sp_dec;

  // Upper address bits are deliberately discarded; the store only spans AW bits.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_addr[ADDR_W-1:AW], start_addr[ADDR_W-1:AW],
                              w_jump[ADDR_W-1:AW]};

  // Word fields decoded from the store entry at the current micro-PC.
  assign word    = store[upc_r];
  assign w_jump  = word[ADDR_W-1:0];
  assign w_cond  = word[ADDR_W +: COND_W];
  assign w_bt    = word[ADDR_W+COND_W];
  assign w_call  = word[ADDR_W+COND_W+1];
  assign w_ret   = word[ADDR_W+COND_W+2];
  assign w_halt  = word[ADDR_W+COND_W+3];
  assign w_ops   = word[MW-1 -: OP_W];

  // cond_sel of zero makes bt a plain "always jump / never jump" bit.
  assign take    = (w_cond == '0) ? w_bt : (cond_in[w_cond] == w_bt);
  assign upc_inc = upc_r + 1'b1;
  assign sp_dec  = sp - 1'b1;

  assign upc  = ADDR_W'(upc_r);
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Microcode store: written only while idle, never reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && ld_en)
      store[ld_addr[AW-1:0]] <= ld_data;
  end

  // Return-address stack storage; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_en)
      stack[sp[SIW-1:0]] <= upc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      upc_r <= '0;
      sp    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      upc_r <= upc_n;
      sp    <= sp_n;
      err   <= err_n;
    end
  end

  // Next-state and micro-PC selection. In RUN the priority is
  // abort > halt > ret > call > branch > increment; stall freezes everything
  // except abort.
  always_comb begin
    state_n   = state;
    upc_n     = upc_r;
    sp_n      = sp;
    err_n     = err;
    push_en   = 1'b0;
    ops       = '0;
    ops_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_RUN;
          upc_n   = start_addr[AW-1:0];
          sp_n    = '0;
          err_n   = 1'b0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          ops       = w_ops;
          ops_valid = 1'b1;
        end
        if (abort) begin
          state_n = ST_IDLE;
          sp_n    = '0;
        end else if (!stall) begin
          if (w_halt) begin
            state_n = ST_DONE;
          end else if (w_ret) begin
            if (sp == '0) begin
              err_n   = 1'b1;
              state_n = ST_IDLE;
            end else begin
              sp_n  = sp_dec;
              upc_n = stack[sp_dec[SIW-1:0]];
            end
          end else if (w_call) begin
            if (sp == SPW'(STACK_DEPTH)) begin
              err_n   = 1'b1;
              state_n = ST_IDLE;
            end else begin
              push_en = 1'b1;
              sp_n    = sp + 1'b1;
              upc_n   = w_jump[AW-1:0];
            end
          end else if (take) begin
            upc_n = w_jump[AW-1:0];
          end else begin
            upc_n = upc_inc;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer
//   Directed self-checking bench for microcode_sequencer: plain sequencing with
//   halt/done, conditional branches, call/return and stack overflow, stall,
//   micro-PC wrap with stack underflow, abort and asynchronous reset.

module tb_microcode_sequencer;

  localparam int ADDR_W      = 16;
  localparam int DEPTH       = 64;
  localparam int OP_W        = 51;
  localparam int COND_W      = 2;
  localparam int STACK_DEPTH = 4;
  localparam int MW          = OP_W + 4 + COND_W + ADDR_W;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   ld_en = 1'b0;
  logic [ADDR_W-1:0]      ld_addr = '0;
  logic [MW-1:0]          ld_data = '0;
  logic                   start = 1'b0;
  logic [ADDR_W-1:0]      start_addr = '0;
  logic                   abort = 1'b0;
  logic                   stall = 1'b0;
  logic [2**COND_W-1:0]   cond_in = '0;
  logic [OP_W-1:0]        ops;
  logic                   ops_valid;
  logic [ADDR_W-1:0]      upc;
  logic                   busy;
  logic                   done;
  logic                   err;

  int checkCount = 0;
  int errorCount = 0;

  microcode_sequencer #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .OP_W(OP_W),
    .COND_W(COND_W), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .start_addr(start_addr), .abort(abort), .stall(stall),
    .cond_in(cond_in), .ops(ops), .ops_valid(ops_valid), .upc(upc),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the run-time control inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic st, input logic ab, input logic [2**COND_W-1:0] cnd);
    stall   = st;
    abort   = ab;
    cond_in = cnd;
    #1;
  endtask

  function automatic logic [MW-1:0] mk(input logic [OP_W-1:0] op, input logic halt,
                                       input logic ret, input logic call, input logic bt,
                                       input logic [COND_W-1:0] cs, input logic [ADDR_W-1:0] ja);
    return {op, halt, ret, call, bt, cs, ja};
  endfunction

  task automatic loadWord(input int addr, input logic [MW-1:0] data);
    ld_en   = 1'b1;
    ld_addr = ADDR_W'(addr);
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic startProgram(input int addr);
    start      = 1'b1;
    start_addr = ADDR_W'(addr);
    tick();
    start      = 1'b0;
  endtask

  task automatic abortProgram();
    applyStimulus(1'b0, 1'b1, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0);
  endtask

  function automatic logic [OP_W-1:0] opv(input int v);
    return OP_W'(v);
  endfunction

  initial begin
    // Reset state
    #12;
    checkOutput("rst_ops",   64'(ops), 64'd0);
    checkOutput("rst_valid", 64'(ops_valid), 64'd0);
    checkOutput("rst_upc",   64'(upc), 64'd0);
    checkOutput("rst_busy",  64'(busy), 64'd0);
    checkOutput("rst_done",  64'(done), 64'd0);
    checkOutput("rst_err",   64'(err), 64'd0);
    rst_n = 1'b1;
    tick();

    // Fill the store with plain words whose ops encode their address.
    for (int i = 0; i < DEPTH; i++)
      loadWord(i, mk(opv(32'h100 + i), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0));

    // Test 1: three plain ops then halt.
    loadWord(0, mk(opv(1), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0));
    loadWord(1, mk(opv(2), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0));
    loadWord(2, mk(opv(3), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0));
    loadWord(3, mk(opv(4), 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0));
    startProgram(0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t1_valid", 64'(ops_valid), 64'd1);
      checkOutput("t1_ops",   64'(ops), 64'(i + 1));
      checkOutput("t1_done",  64'(done), 64'd0);
      tick();
    end
    checkOutput("t1_done_pulse", 64'(done), 64'd1);
    checkOutput("t1_valid_done", 64'(ops_valid), 64'd0);
    checkOutput("t1_busy_done",  64'(busy), 64'd1);
    tick();
    checkOutput("t1_done_end", 64'(done), 64'd0);
    checkOutput("t1_busy_end", 64'(busy), 64'd0);
    checkOutput("t1_upc_idle", 64'(upc), 64'd3);

    // Test 2: conditional branch on cond_in[1] == bt.
    loadWord(5, mk(opv(32'h55), 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'd9));
    applyStimulus(1'b0, 1'b0, 4'b0010);
    startProgram(5);
    checkOutput("t2_upc_start", 64'(upc), 64'd5);
    checkOutput("t2_ops", 64'(ops), 64'h55);
    tick();
    checkOutput("t2_taken", 64'(upc), 64'd9);
    abortProgram();
    applyStimulus(1'b0, 1'b0, 4'b0000);
    startProgram(5);
    tick();
    checkOutput("t2_not_taken", 64'(upc), 64'd6);
    abortProgram();

    // Test 3: call and return, then stack overflow.
    loadWord(2, mk(opv(3), 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd20));
    loadWord(20, mk(opv(32'h20), 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0));
    startProgram(2);
    checkOutput("t3_upc_call", 64'(upc), 64'd2);
    tick();
    checkOutput("t3_upc_sub", 64'(upc), 64'd20);
    tick();
    checkOutput("t3_upc_ret", 64'(upc), 64'd3);
    checkOutput("t3_err_ok", 64'(err), 64'd0);
    abortProgram();
    for (int i = 30; i < 35; i++)
      loadWord(i, mk(opv(i), 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, ADDR_W'(i + 1)));
    startProgram(30);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("t3_nest_upc",  64'(upc), 64'd34);
    checkOutput("t3_nest_err0", 64'(err), 64'd0);
    tick();
    checkOutput("t3_ovf_err",  64'(err), 64'd1);
    checkOutput("t3_ovf_busy", 64'(busy), 64'd0);

    // Test 4: stall held for three cycles at upc 4.
    startProgram(4);
    checkOutput("t4_err_cleared", 64'(err), 64'd0);
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4_stall_upc",   64'(upc), 64'd4);
      checkOutput("t4_stall_valid", 64'(ops_valid), 64'd0);
      checkOutput("t4_stall_ops",   64'(ops), 64'd0);
      if (i < 2) tick();
    end
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("t4_resume_valid", 64'(ops_valid), 64'd1);
    checkOutput("t4_resume_ops",   64'(ops), 64'h104);
    tick();
    checkOutput("t4_resume_upc", 64'(upc), 64'd5);
    abortProgram();

    // Test 6a: abort at upc 7.
    startProgram(6);
    tick();
    checkOutput("t6_upc7", 64'(upc), 64'd7);
    applyStimulus(1'b0, 1'b1, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("t6_abort_busy", 64'(busy), 64'd0);
    checkOutput("t6_abort_done", 64'(done), 64'd0);

    // Test 5: wrap DEPTH-1 -> 0, then ret with an empty stack.
    loadWord(0, mk(opv(32'h77), 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0));
    startProgram(DEPTH - 1);
    checkOutput("t5_upc_top", 64'(upc), 64'(DEPTH - 1));
    tick();
    checkOutput("t5_wrap", 64'(upc), 64'd0);
    tick();
    checkOutput("t5_unf_err",  64'(err), 64'd1);
    checkOutput("t5_unf_busy", 64'(busy), 64'd0);

    // Test 6b: asynchronous reset mid-run.
    startProgram(10);
    tick();
    checkOutput("t6_run_upc", 64'(upc), 64'd11);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_ops",   64'(ops), 64'd0);
    checkOutput("t6_rst_valid", 64'(ops_valid), 64'd0);
    checkOutput("t6_rst_upc",   64'(upc), 64'd0);
    checkOutput("t6_rst_busy",  64'(busy), 64'd0);
    checkOutput("t6_rst_done",  64'(done), 64'd0);
    checkOutput("t6_rst_err",   64'(err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
